vram_port_arbiter: RTL and testbench

- Shares the single-port text VRAM (600 x 32-bit words, BRAM, 1-cycle read latency) between two requesters.
- Requester 1 is the text renderer's glyph/attribute fetch ("vid"). Requester 2 is the AXI4-Lite slave register logic ("host").
- Sits between the AXI slave decode and the VRAM inside hdmi_text_controller.
- Serialises accesses, applies byte strobes, and routes read data back to the owning requester.

---
 rtl/vram_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_vram_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter.sv
// Two-requester arbiter in front of the single-port text VRAM: serialises renderer and host accesses.
// Optional starvation guard for the host side is enabled by defining VRAM_ARB_STARVE_GUARD_EN.
module vram_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int VRAM_WORDS   = 600,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                axi_aclk,
    input  logic                axi_areset,
    input  logic                vid_req,
    input  logic [ADDR_W-1:0]   vid_addr,
    output logic                vid_gnt,
    output logic                vid_rvalid,
    output logic [DATA_W-1:0]   vid_rdata,
    input  logic                host_req,
    input  logic                host_we,
    input  logic [ADDR_W-1:0]   host_addr,
    input  logic [DATA_W-1:0]   host_wdata,
    input  logic [DATA_W/8-1:0] host_wstrb,
    output logic                host_gnt,
    output logic                host_wdone,
    output logic                host_rvalid,
    output logic [DATA_W-1:0]   host_rdata,
    output logic                host_err,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    if (STARVE_LIMIT < 1 || (DATA_W % 8) != 0) begin : g_bad_cfg
        $error("vram_port_arbiter: STARVE_LIMIT must be >= 1 and DATA_W a multiple of 8");
    end

    // Memory-slot tags (VID/HRD/HWR) and host error tags (HERR_*) travel in separate
    // registers because an out-of-range host access may be granted alongside vid.
    typedef enum logic [2:0] {
        TAG_NONE,
        TAG_VID,
        TAG_HRD,
        TAG_HWR,
        TAG_HERR_RD,
        TAG_HERR_WR
    } tag_t;

    tag_t              s1_mem_nxt, s1_err_nxt;
    tag_t              s1_mem_tag, s1_err_tag;
    tag_t              s2_mem_tag, s2_err_tag;
    logic [DATA_W-1:0] vid_rdata_q, host_rdata_q;
    logic              host_oor;
    logic              force_host;

    // Range test on the full address width, so aliases above VRAM_WORDS never reach the BRAM.
    assign host_oor = (32'(host_addr) >= 32'(VRAM_WORDS));

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign force_host = host_req && !host_oor && (starve_cnt == CNT_W'(STARVE_LIMIT));

    always_ff @(posedge axi_aclk) begin
        if (axi_areset || !host_req || host_gnt) begin
            starve_cnt <= '0;
        end else if (!host_oor) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    assign force_host = 1'b0;
`endif

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        vid_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (!axi_areset) begin
            vid_gnt  = vid_req && !force_host;
            host_gnt = host_req && (host_oor || !vid_req || force_host);
        end
    end

    always_comb begin
        s1_mem_nxt = TAG_NONE;
        s1_err_nxt = TAG_NONE;
        if (vid_gnt) begin
            s1_mem_nxt = TAG_VID;
        end else if (host_gnt && !host_oor) begin
            s1_mem_nxt = host_we ? TAG_HWR : TAG_HRD;
        end
        if (host_gnt && host_oor) begin
            s1_err_nxt = host_we ? TAG_HERR_WR : TAG_HERR_RD;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            s1_mem_tag   <= TAG_NONE;
            s1_err_tag   <= TAG_NONE;
            s2_mem_tag   <= TAG_NONE;
            s2_err_tag   <= TAG_NONE;
            mem_en       <= 1'b0;
            mem_we       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            vid_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            s1_mem_tag <= s1_mem_nxt;
            s1_err_tag <= s1_err_nxt;
            mem_en     <= (s1_mem_nxt != TAG_NONE);
            mem_we     <= (s1_mem_nxt == TAG_HWR) ? host_wstrb : '0;

            // Address and write data hold their last values while the port is idle.
            if (s1_mem_nxt == TAG_VID) begin
                mem_addr <= vid_addr;
            end else if (s1_mem_nxt != TAG_NONE) begin
                mem_addr <= host_addr;
            end
            if (s1_mem_nxt == TAG_HWR) begin
                mem_wdata <= host_wdata;
            end

            // Only reads advance to stage 2; writes complete in stage 1.
            s2_mem_tag <= (s1_mem_tag == TAG_VID || s1_mem_tag == TAG_HRD) ? s1_mem_tag : TAG_NONE;
            s2_err_tag <= (s1_err_tag == TAG_HERR_RD) ? TAG_HERR_RD : TAG_NONE;

            vid_rdata_q  <= vid_rdata;
            host_rdata_q <= host_rdata;
        end
    end

    always_comb begin
        vid_rvalid  = (s2_mem_tag == TAG_VID);
        host_rvalid = (s2_mem_tag == TAG_HRD) || (s2_err_tag == TAG_HERR_RD);
        host_wdone  = (s1_mem_tag == TAG_HWR) || (s1_err_tag == TAG_HERR_WR);
        host_err    = (s1_err_tag == TAG_HERR_WR) || (s2_err_tag == TAG_HERR_RD);

        vid_rdata = vid_rdata_q;
        if (s2_mem_tag == TAG_VID) begin
            vid_rdata = mem_rdata;
        end

        host_rdata = host_rdata_q;
        if (s2_mem_tag == TAG_HRD) begin
            host_rdata = mem_rdata;
        end else if (s2_err_tag == TAG_HERR_RD) begin
            host_rdata = '0;
        end
    end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a BRAM model, reference memory and read scoreboards.
// Build with VRAM_ARB_STARVE_GUARD_EN defined to exercise the host starvation guard.
module tb_vram_port_arbiter;

    localparam int ADDR_W       = 10;
    localparam int DATA_W       = 32;
    localparam int STRB_W       = DATA_W / 8;
    localparam int VRAM_WORDS   = 600;
    localparam int STARVE_LIMIT = 8;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              axi_aclk = 1'b0;
    logic              axi_areset;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt;
    logic              vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [STRB_W-1:0] host_wstrb;
    logic              host_gnt;
    logic              host_wdone;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic              host_err;
    logic              mem_en;
    logic [STRB_W-1:0] mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] vid_q [$];
    logic [DATA_W:0]   host_q [$];
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] bram    [0:(1<<ADDR_W)-1];
    logic              bram_loaded = 1'b0;

    logic [116:0] all_outs;
    assign all_outs = {vid_gnt, vid_rvalid, vid_rdata, host_gnt, host_wdone, host_rvalid,
                       host_rdata, host_err, mem_en, mem_we, mem_addr, mem_wdata};

    always #5 axi_aclk = ~axi_aclk;

    vram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .VRAM_WORDS(VRAM_WORDS), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .axi_aclk(axi_aclk), .axi_areset(axi_areset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_wstrb(host_wstrb), .host_gnt(host_gnt),
        .host_wdone(host_wdone), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .host_err(host_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [DATA_W-1:0] pattern(input int a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    // Single-port BRAM, read-first, one cycle of read latency.
    always @(posedge axi_aclk) begin
        if (!bram_loaded) begin
            for (int i = 0; i < (1 << ADDR_W); i++) bram[i] <= pattern(i);
            bram_loaded <= 1'b1;
        end else if (mem_en) begin
            for (int b = 0; b < STRB_W; b++)
                if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= bram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every read response is matched against the next queued expectation.
    always @(negedge axi_aclk) begin
        if (vid_rvalid === 1'b1) begin
            check("vid_resp_expected", 128'(vid_q.size() != 0), 128'(1));
            if (vid_q.size() != 0) check("vid_rdata", 128'(vid_rdata), 128'(vid_q.pop_front()));
        end
        if (host_rvalid === 1'b1) begin
            check("host_resp_expected", 128'(host_q.size() != 0), 128'(1));
            if (host_q.size() != 0)
                check("host_err_rdata", 128'({host_err, host_rdata}), 128'(host_q.pop_front()));
        end
    end

    function automatic void ref_write(input int addr, input logic [DATA_W-1:0] d,
                                      input logic [STRB_W-1:0] s);
        if (addr < VRAM_WORDS)
            for (int b = 0; b < STRB_W; b++)
                if (s[b]) ref_mem[addr][8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic next_cycle();
        @(posedge axi_aclk);
        #1;
    endtask

    // One host request cycle with vid idle; returns one cycle after the grant with host_req low.
    task automatic host_go(input logic we, input int addr, input logic [DATA_W-1:0] d,
                           input logic [STRB_W-1:0] s, input string tag);
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = ADDR_W'(addr);
        host_wdata = d;
        host_wstrb = s;
        #1;
        check(tag, 128'(host_gnt), 128'(1));
        if (we) ref_write(addr, d, s);
        else if (addr >= VRAM_WORDS) host_q.push_back({1'b1, 32'h0});
        else host_q.push_back({1'b0, ref_mem[addr]});
        next_cycle();
        host_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = pattern(i);
        axi_areset = 1'b1;
        vid_req    = 1'b1;
        vid_addr   = 10'd10;
        host_req   = 1'b1;
        host_we    = 1'b0;
        host_addr  = 10'd3;
        host_wdata = '0;
        host_wstrb = '0;

        // Reset held four cycles with both requests pending.
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            #1;
            check("reset_outputs", 128'(all_outs), 128'(0));
        end
        axi_areset = 1'b0;
        #1;
        check("release_gnts", 128'({vid_gnt, host_gnt}), 128'(2'b10));
        vid_q.push_back(ref_mem[10]);
        next_cycle();
        vid_req  = 1'b0;
        host_req = 1'b0;
        #1;
        check("vid_stage1", 128'({mem_en, mem_we, mem_addr}), 128'({1'b1, 4'h0, 10'd10}));
        next_cycle();
        #1;
        check("vid_rvalid_n2", 128'(vid_rvalid), 128'(1));
        next_cycle();

        // Host write then read of address 1.
        host_go(1'b1, 1, 32'h0067_00FF, 4'hF, "wr_gnt");
        #1;
        check("wr_stage1", 128'({mem_en, mem_we, mem_addr, mem_wdata, host_wdone, host_err}),
              128'({1'b1, 4'hF, 10'd1, 32'h0067_00FF, 1'b1, 1'b0}));
        next_cycle();
        #1;
        check("idle_hold", 128'({mem_en, mem_we, mem_addr, host_wdone}), 128'({1'b0, 4'h0, 10'd1, 1'b0}));
        next_cycle();
        host_go(1'b0, 1, '0, '0, "rd_gnt");
        #1;
        check("rd_stage1", 128'({mem_en, mem_we, host_rvalid}), 128'({1'b1, 4'h0, 1'b0}));
        next_cycle();
        #1;
        check("rd_resp", 128'({host_rvalid, host_err, host_rdata}), 128'({1'b1, 1'b0, 32'h0067_00FF}));
        next_cycle();

        // Byte strobes, back-to-back grants.
        host_go(1'b1, 7, 32'h1122_3344, 4'hF, "strb_wr1_gnt");
        host_go(1'b1, 7, 32'hAABB_CCDD, 4'h2, "strb_wr2_gnt");
        host_go(1'b0, 7, '0, '0, "strb_rd_gnt");
        next_cycle();
        #1;
        check("strb_resp", 128'({host_rvalid, host_rdata}), 128'({1'b1, 32'h1122_CC44}));
        next_cycle();

        // Contention: vid held 20 cycles, host read of address 5 pending from the first.
        vid_req   = 1'b1;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 10'd5;
        for (int i = 0; i < 20; i++) begin
            logic exp_h;
            vid_addr = ADDR_W'(100 + i);
            #1;
            exp_h = GUARD && (i == STARVE_LIMIT);
            check("cont_gnts", 128'({host_gnt, vid_gnt}), 128'({exp_h, !exp_h}));
            if (exp_h) host_q.push_back({1'b0, ref_mem[5]});
            else vid_q.push_back(ref_mem[100 + i]);
            next_cycle();
            if (exp_h) host_req = 1'b0;
        end
        vid_req = 1'b0;
`ifndef VRAM_ARB_STARVE_GUARD_EN
        #1;
        check("cont_host_after_vid", 128'(host_gnt), 128'(1));
        host_q.push_back({1'b0, ref_mem[5]});
        next_cycle();
        host_req = 1'b0;
`endif
        repeat (3) next_cycle();

        // Out-of-range read granted alongside vid.
        vid_req   = 1'b1;
        vid_addr  = 10'd30;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 10'd600;
        #1;
        check("oor_gnts", 128'({host_gnt, vid_gnt}), 128'(2'b11));
        vid_q.push_back(ref_mem[30]);
        host_q.push_back({1'b1, 32'h0});
        next_cycle();
        vid_req  = 1'b0;
        host_req = 1'b0;
        #1;
        check("oor_stage1", 128'({mem_en, mem_addr, host_wdone}), 128'({1'b1, 10'd30, 1'b0}));
        next_cycle();
        #1;
        check("oor_resp", 128'({host_rvalid, host_err, host_rdata, vid_rvalid}),
              128'({1'b1, 1'b1, 32'h0, 1'b1}));
        next_cycle();

        // Out-of-range write at the top of the address space is dropped.
        host_go(1'b1, 1023, 32'hDEAD_BEEF, 4'hF, "oor_wr_gnt");
        #1;
        check("oor_wr_done", 128'({host_wdone, host_err, mem_en, mem_we}), 128'({1'b1, 1'b1, 1'b0, 4'h0}));
        next_cycle();

        // Last valid word is in range.
        host_go(1'b0, VRAM_WORDS - 1, '0, '0, "last_word_gnt");
        next_cycle();
        #1;
        check("last_word_resp", 128'({host_rvalid, host_err}), 128'(2'b10));
        next_cycle();

        // Reset in the cycle after a host read grant discards the read.
        host_go(1'b0, 1, '0, '0, "rst_rd_gnt");
        void'(host_q.pop_back());
        axi_areset = 1'b1;
        next_cycle();
        #1;
        check("rst_mid_outputs", 128'(all_outs), 128'(0));
        axi_areset = 1'b0;
        repeat (4) next_cycle();

        check("vid_q_drained", 128'(vid_q.size()), 128'(0));
        check("host_q_drained", 128'(host_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
